// File: rtl/irq_dispatch_if.sv
// ---------------------------------------------------------------------------
// irq_dispatch_if
// Groups the CSR access bus and the core request/ack handshake of the
// interrupt dispatcher.
//
// Signals:
//   csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data : CSR access from core
//   csr_out                                          : CSR read data
//   core_req, core_id, core_prio                     : request to core
//   core_ack, core_done                              : handler entry / exit
//
// csr_op encoding: bit2 = take operand from rs1_zimm instead of rs1_data,
// bits[1:0] = 00 read only, 01 write, 10 set, 11 clear.
//
// Modports: master = dispatcher side, slave = core side.
// ---------------------------------------------------------------------------
interface irq_dispatch_if #(
    parameter int NumIrq    = 8,
    parameter int PrioWidth = 3
);
    localparam int IdW = (NumIrq > 1) ? $clog2(NumIrq) : 1;

    typedef logic [2:0] csr_op_t;

    logic                 csr_enable;
    logic [11:0]          csr_addr;
    csr_op_t              csr_op;
    logic [4:0]           rs1_zimm;
    logic [31:0]          rs1_data;
    logic [31:0]          csr_out;

    logic                 core_req;
    logic [IdW-1:0]       core_id;
    logic [PrioWidth-1:0] core_prio;
    logic                 core_ack;
    logic                 core_done;

    modport master (
        input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        input  core_ack, core_done,
        output csr_out, core_req, core_id, core_prio
    );

    modport slave (
        output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        output core_ack, core_done,
        input  csr_out, core_req, core_id, core_prio
    );
endinterface

// File: rtl/irq_dispatch.sv
// ---------------------------------------------------------------------------
// irq_dispatch
// Interrupt dispatcher: arbitrates level-held peripheral interrupt lines by
// CSR-programmed priority, hands the winner to the core over a req/ack
// handshake, pulses the clear line of the dispatched source, and keeps a
// stack of preempted priority levels until the core signals handler exit.
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high reset
//   bus               irq_dispatch_if.master (CSR bus + core handshake)
//   i_irq_pending_in  peripheral interrupt_set lines
//   o_irq_clear_out   one-cycle interrupt_clear pulses
//   o_level           current running priority level
//
// CSRs: cfg[i] at Base+i (bit0 enable, bits[PrioWidth:1] priority),
//       level at Base+NumIrq (read-only).
//
// Optional feature macro: IRQ_DISPATCH_TAILCHAIN_EN
//   When defined, a handler exit that finds a waiting source above the level
//   it would restore skips the pop and requests that source immediately; its
//   ack then replaces the level instead of pushing.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no request outstanding; arbitrating against current level
// S_REQ      | first cycle core_req is presented
// S_WAIT_ACK | core_req still presented, waiting for core_ack
// ---------------------------------------------------------------------------
module irq_dispatch #(
    parameter int          NumIrq    = 8,
    parameter int          PrioWidth = 3,
    parameter int          NestDepth = 4,
    parameter logic [11:0] Base      = 12'hB00
) (
    input  logic                 clk,
    input  logic                 reset,
    irq_dispatch_if.master       bus,
    input  logic [NumIrq-1:0]    i_irq_pending_in,
    output logic [NumIrq-1:0]    o_irq_clear_out,
    output logic [PrioWidth-1:0] o_level
);
    localparam int IdW    = (NumIrq > 1) ? $clog2(NumIrq) : 1;
    localparam int DepthW = $clog2(NestDepth + 1);
    localparam int SIdxW  = (NestDepth > 1) ? $clog2(NestDepth) : 1;
    localparam int CfgW   = PrioWidth + 1;
    localparam int ArbW   = 1 + IdW + PrioWidth;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK} state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [NumIrq-1:0]                   r_en;
    logic [NumIrq-1:0][PrioWidth-1:0]    r_prio;
    logic [PrioWidth-1:0]                r_level;
    logic [NestDepth-1:0][PrioWidth-1:0] r_stack;
    logic [DepthW-1:0]                   r_depth;
    logic                                r_core_req;
    logic [IdW-1:0]                      r_core_id;
    logic [PrioWidth-1:0]                r_core_prio;
    logic [NumIrq-1:0]                   r_clear;

    // ---------------- CSR access ----------------
    logic [11:0]     w_csr_off;
    logic            w_hit_cfg;
    logic            w_hit_lvl;
    logic [IdW-1:0]  w_csr_idx;
    logic [CfgW-1:0] w_cfg_old;
    logic [CfgW-1:0] w_cfg_new;
    logic [31:0]     w_operand;
    logic [CfgW-1:0] w_opnd;
    logic            w_cfg_we;
    logic [31:0]     w_csr_out;

    assign w_csr_off = bus.csr_addr - Base;
    assign w_hit_cfg = w_csr_off < 12'(NumIrq);
    assign w_hit_lvl = w_csr_off == 12'(NumIrq);
    assign w_csr_idx = w_csr_off[IdW-1:0];
    assign w_cfg_old = {r_prio[w_csr_idx], r_en[w_csr_idx]};
    assign w_operand = bus.csr_op[2] ? {27'b0, bus.rs1_zimm} : bus.rs1_data;
    assign w_opnd    = w_operand[CfgW-1:0];
    assign w_cfg_we  = bus.csr_enable && w_hit_cfg && (bus.csr_op[1:0] != 2'b00);

    always_comb begin
        w_cfg_new = w_cfg_old;
        case (bus.csr_op[1:0])
            OP_WRITE: w_cfg_new = w_opnd;
            OP_SET:   w_cfg_new = w_cfg_old | w_opnd;
            OP_CLEAR: w_cfg_new = w_cfg_old & ~w_opnd;
            default:  w_cfg_new = w_cfg_old;
        endcase
    end

    always_comb begin
        w_csr_out = '0;
        if (w_hit_cfg) begin
            w_csr_out[CfgW-1:0] = w_cfg_old;
        end else if (w_hit_lvl) begin
            w_csr_out[PrioWidth-1:0] = r_level;
        end
    end

    // ---------------- arbitration ----------------
    // Strict '>' against the running best keeps the lowest index on ties;
    // prio > thr >= 0 already excludes priority 0.
    function automatic logic [ArbW-1:0] f_arb(
        input logic [NumIrq-1:0]                cand,
        input logic [NumIrq-1:0][PrioWidth-1:0] prio,
        input logic [PrioWidth-1:0]             thr
    );
        logic [IdW-1:0]       best_id;
        logic [PrioWidth-1:0] best_prio;
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NumIrq; i++) begin
            if (cand[i] && (prio[i] > thr) && (prio[i] > best_prio)) begin
                best_id   = IdW'(i);
                best_prio = prio[i];
            end
        end
        return {best_prio != '0, best_id, best_prio};
    endfunction

    logic [NumIrq-1:0]    w_cand;
    logic                 w_found;
    logic [IdW-1:0]       w_win_id;
    logic [PrioWidth-1:0] w_win_prio;

    assign w_cand = i_irq_pending_in & r_en;
    assign {w_found, w_win_id, w_win_prio} = f_arb(w_cand, r_prio, r_level);

    // ---------------- level stack ----------------
    logic [DepthW-1:0]    w_depth_m1;
    logic [PrioWidth-1:0] w_top;
    logic                 w_done_ok;
    logic                 w_room;

    assign w_depth_m1 = r_depth - DepthW'(1);
    assign w_top      = r_stack[w_depth_m1[SIdxW-1:0]];
    assign w_done_ok  = bus.core_done && (r_depth != '0);
    assign w_room     = r_depth < DepthW'(NestDepth);

`ifdef IRQ_DISPATCH_TAILCHAIN_EN
    logic                 r_tail;
    logic                 w_tail;
    logic                 w_tc_found;
    logic [IdW-1:0]       w_tc_id;
    logic [PrioWidth-1:0] w_tc_prio;

    // Arbitrate against the level a pop would restore.
    assign {w_tc_found, w_tc_id, w_tc_prio} = f_arb(w_cand, r_prio, w_top);
`endif

    // ---------------- FSM ----------------
    logic w_capture;
    logic w_ack_take;
    logic w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ack_take  = 1'b0;
        w_pop       = 1'b0;
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
        w_tail      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // A pop takes the cycle; arbitration sees the restored level next cycle.
                if (w_done_ok) begin
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
                    if (w_tc_found) begin
                        w_tail      = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_pop = 1'b1;
                    end
`else
                    w_pop = 1'b1;
`endif
                end else if (w_found && w_room) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ, S_WAIT_ACK: begin
                // Ack wins over a same-cycle done.
                if (bus.core_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pop       = w_done_ok;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en        <= '0;
            r_prio      <= '0;
            r_level     <= '0;
            r_stack     <= '0;
            r_depth     <= '0;
            r_core_req  <= 1'b0;
            r_core_id   <= '0;
            r_core_prio <= '0;
            r_clear     <= '0;
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
            r_tail      <= 1'b0;
`endif
        end else begin
            r_clear <= '0;
            if (w_cfg_we) begin
                r_en[w_csr_idx]   <= w_cfg_new[0];
                r_prio[w_csr_idx] <= w_cfg_new[CfgW-1:1];
            end
            if (w_capture) begin
                r_core_req  <= 1'b1;
                r_core_id   <= w_win_id;
                r_core_prio <= w_win_prio;
            end
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
            if (w_tail) begin
                r_core_req  <= 1'b1;
                r_core_id   <= w_tc_id;
                r_core_prio <= w_tc_prio;
                r_tail      <= 1'b1;
            end
`endif
            if (w_ack_take) begin
                r_core_req          <= 1'b0;
                r_clear[r_core_id]  <= 1'b1;
                r_level             <= r_core_prio;
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
                r_tail <= 1'b0;
                if (!r_tail) begin
                    r_stack[r_depth[SIdxW-1:0]] <= r_level;
                    r_depth                     <= r_depth + DepthW'(1);
                end
`else
                r_stack[r_depth[SIdxW-1:0]] <= r_level;
                r_depth                     <= r_depth + DepthW'(1);
`endif
            end
            if (w_pop) begin
                r_level <= w_top;
                r_depth <= w_depth_m1;
            end
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^{w_operand, w_depth_m1};

    assign bus.csr_out     = w_csr_out;
    assign bus.core_req    = r_core_req;
    assign bus.core_id     = r_core_id;
    assign bus.core_prio   = r_core_prio;
    assign o_irq_clear_out = r_clear;
    assign o_level         = r_level;
endmodule
